// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: arbitrary-depth single-clock FIFO with level flags, occupancy count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses registered reads.
module sync_fifo_flags #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 10,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_acc;
   logic             pop_acc;
   logic             push_rej;
   logic             pop_rej;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
   assign push_acc = push && (!full || pop);
   assign pop_acc  = pop && !empty;
   assign push_rej = push && full && !pop;
   assign pop_rej  = pop && empty;

   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop_acc) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push_acc, pop_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A new error in the same cycle as clr_err wins, so no event is ever silently dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_rej) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (pop_rej) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_data  = mem[rd_ptr];
   assign rd_valid = !empty;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop_acc;
         if (pop_acc) begin
            rd_data <= mem[rd_ptr];
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (DEPTH=10, AF_THRESH=8, AE_THRESH=2).
// Build with SYNC_FIFO_FWFT_EN defined to check the first-word-fall-through read mode.
module tb_sync_fifo_flags;

   localparam int WIDTH = 8;
   localparam int DEPTH = 10;
   localparam int AF    = 8;
   localparam int AE    = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             push;
   logic [WIDTH-1:0] wr_data;
   logic             pop;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;
   logic             clr_err;

   int checks = 0;
   int passes = 0;

   sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1ns after the rising edge, well clear of it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic p, input logic [WIDTH-1:0] d, input logic q, input logic c);
      push    = p;
      wr_data = d;
      pop     = q;
      clr_err = c;
      tick();
      push    = 1'b0;
      pop     = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic checkLevel(input string tag, input int n);
      checkOutput($sformatf("%s count", tag), 32'(count), 32'(n));
      checkOutput($sformatf("%s empty", tag), 32'(empty), 32'(n == 0));
      checkOutput($sformatf("%s full", tag), 32'(full), 32'(n == DEPTH));
      checkOutput($sformatf("%s almost_empty", tag), 32'(almost_empty), 32'(n <= AE));
      checkOutput($sformatf("%s almost_full", tag), 32'(almost_full), 32'(n >= AF));
   endtask

   task automatic checkErrors(input string tag, input logic ovf, input logic unf);
      checkOutput($sformatf("%s overflow", tag), 32'(overflow), 32'(ovf));
      checkOutput($sformatf("%s underflow", tag), 32'(underflow), 32'(unf));
   endtask

   task automatic popWord(input string tag, input logic [WIDTH-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput($sformatf("%s rd_valid", tag), 32'(rd_valid), 32'd1);
      checkOutput($sformatf("%s rd_data", tag), 32'(rd_data), 32'(exp));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
`else
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput($sformatf("%s rd_valid", tag), 32'(rd_valid), 32'd1);
      checkOutput($sformatf("%s rd_data", tag), 32'(rd_data), 32'(exp));
`endif
   endtask

   task automatic fillFrom(input string tag, input logic [WIDTH-1:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, base + WIDTH'(i), 1'b0, 1'b0);
         checkLevel($sformatf("%s fill%0d", tag, i + 1), i + 1);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      clr_err = 1'b0;
      wr_data = '0;
      #12;
      checkLevel("reset", 0);
      checkErrors("reset", 1'b0, 1'b0);
      checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      checkOutput("reset rd_data", 32'(rd_data), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      $display("[TB] fill 0x01..0x0A then drain");
      fillFrom("seq", 8'h01);
      for (int i = 0; i < DEPTH; i++) begin
         popWord($sformatf("seq pop%0d", i + 1), 8'h01 + WIDTH'(i));
         checkLevel($sformatf("seq drain%0d", i + 1), DEPTH - 1 - i);
      end
      checkErrors("seq", 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("seq idle rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("seq idle rd_data hold", 32'(rd_data), 32'h0A);
`endif

      $display("[TB] overflow and clear");
      fillFrom("ovf", 8'h10);
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      checkLevel("ovf reject", DEPTH);
      checkErrors("ovf reject", 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkErrors("ovf clear", 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         popWord($sformatf("ovf pop%0d", i + 1), 8'h10 + WIDTH'(i));
      end
      checkLevel("ovf drained", 0);

      $display("[TB] underflow, push+pop on empty, set-wins clear");
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkLevel("unf reject", 0);
      checkErrors("unf reject", 1'b0, 1'b1);
      checkOutput("unf rd_valid", 32'(rd_valid), 32'd0);
      applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
      checkLevel("unf pushpop", 1);
      checkErrors("unf pushpop", 1'b0, 1'b1);
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput("unf pushpop rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("unf pushpop rd_data", 32'(rd_data), 32'h33);
`else
      checkOutput("unf pushpop rd_valid", 32'(rd_valid), 32'd0);
`endif
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkErrors("unf clear", 1'b0, 1'b0);
      popWord("unf pop", 8'h33);
      checkLevel("unf drained", 0);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkErrors("unf setwins", 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkErrors("unf clear2", 1'b0, 1'b0);

      $display("[TB] push+pop while full");
      fillFrom("fpp", 8'h40);
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput("fpp head", 32'(rd_data), 32'h40);
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
`else
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
      checkOutput("fpp rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("fpp rd_data", 32'(rd_data), 32'h40);
`endif
      checkLevel("fpp", DEPTH);
      checkErrors("fpp", 1'b0, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         popWord($sformatf("fpp pop%0d", i), 8'h40 + WIDTH'(i));
      end
      popWord("fpp last", 8'hAA);
      checkLevel("fpp drained", 0);

      $display("[TB] async reset mid-burst");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h50 + WIDTH'(i), 1'b0, 1'b0);
      end
      checkLevel("rst before", 5);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkErrors("rst before", 1'b0, 1'b0);
      push    = 1'b1;
      wr_data = 8'h5F;
      #2;
      rst_n = 1'b0;
      #1;
      checkLevel("rst async", 0);
      checkOutput("rst async rd_valid", 32'(rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      checkOutput("rst async rd_data", 32'(rd_data), 32'd0);
`endif
      push = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checkLevel("rst after", 0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      checkLevel("rst push", 1);
      popWord("rst pop", 8'h77);
      checkLevel("rst drained", 0);
      checkErrors("rst end", 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
